// File: rtl/dmem_port_arbiter_pkg.sv
// rtl/dmem_port_arbiter_pkg.sv - shared types and defaults for the data-memory port arbiter
package dmem_port_arbiter_pkg;

    localparam int DMEM_WORD_W       = 16;
    localparam int DMEM_MASK_W       = DMEM_WORD_W / 8;
    localparam int DMEM_STARVE_LIMIT = 4;

    typedef struct packed {
        logic                   w;
        logic [DMEM_WORD_W-1:0] addr;
        logic [DMEM_WORD_W-1:0] wdata;
        logic [DMEM_MASK_W-1:0] wmask;
    } dmem_req_t;

endpackage

// File: rtl/dmem_port_arbiter.sv
// rtl/dmem_port_arbiter.sv - shares the data-memory port between LSU loads and store-buffer drains
module dmem_port_arbiter
    import dmem_port_arbiter_pkg::*;
#(
    parameter int WORD_SIZE_P  = DMEM_WORD_W,
    parameter int MASK_W       = WORD_SIZE_P / 8,
    parameter int ROB_ENTRY    = 8,
    parameter int TAG_W        = $clog2(ROB_ENTRY),
    parameter int STARVE_LIMIT = DMEM_STARVE_LIMIT
) (
    input  logic                   clk_i,
    input  logic                   reset_i,
    input  logic                   ld_v_i,
    input  logic [WORD_SIZE_P-1:0] ld_addr_i,
    input  logic [TAG_W-1:0]       ld_tag_i,
    output logic                   ld_ready_o,
    output logic                   ld_resp_v_o,
    output logic [TAG_W-1:0]       ld_resp_tag_o,
    output logic [WORD_SIZE_P-1:0] ld_resp_data_o,
    input  logic                   st_v_i,
    input  logic [WORD_SIZE_P-1:0] st_addr_i,
    input  logic [WORD_SIZE_P-1:0] st_data_i,
    input  logic [MASK_W-1:0]      st_mask_i,
    input  logic                   st_urgent_i,
    output logic                   st_ready_o,
    input  logic                   mispredict_i,
    output logic                   mem_v_o,
    output logic                   mem_w_o,
    output logic [WORD_SIZE_P-1:0] mem_addr_o,
    output logic [WORD_SIZE_P-1:0] mem_wdata_o,
    output logic [MASK_W-1:0]      mem_wmask_o,
    input  logic                   mem_ready_i,
    input  logic [WORD_SIZE_P-1:0] mem_rdata_i
);

    localparam int              CNT_W   = $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_LIMIT);

    logic [CNT_W-1:0] starve_cnt;
    logic             rd_pend;
    logic             rd_kill;
    logic [TAG_W-1:0] rd_tag;

    logic      ld_eff;
    logic      store_sel;
    logic      load_sel;
    logic      ld_acc;
    logic      st_acc;
    dmem_req_t req;

    // Stores win when no live load competes, when the SB is full, or when they have lost too often.
    always_comb begin
        ld_eff    = ld_v_i & ~mispredict_i;
        store_sel = st_v_i & (~ld_eff | st_urgent_i | (starve_cnt == CNT_MAX));
        load_sel  = ld_eff & ~store_sel;
        st_acc    = ~reset_i & store_sel & mem_ready_i;
        ld_acc    = ~reset_i & load_sel & mem_ready_i;

        req = '0;
        if (store_sel) begin
            req.w     = 1'b1;
            req.addr  = st_addr_i;
            req.wdata = st_data_i;
            req.wmask = st_mask_i;
        end else if (load_sel) begin
            req.addr = ld_addr_i;
        end
    end

    assign mem_v_o     = ~reset_i & (store_sel | load_sel);
    assign mem_w_o     = ~reset_i & req.w;
    assign mem_addr_o  = reset_i ? '0 : req.addr;
    assign mem_wdata_o = reset_i ? '0 : req.wdata;
    assign mem_wmask_o = reset_i ? '0 : req.wmask;
    assign ld_ready_o  = ld_acc;
    assign st_ready_o  = st_acc;

    // Read data comes straight from memory one cycle after acceptance; only the tag is registered.
    assign ld_resp_v_o    = ~reset_i & rd_pend & ~mispredict_i & ~rd_kill;
    assign ld_resp_tag_o  = reset_i ? '0 : rd_tag;
    assign ld_resp_data_o = reset_i ? '0 : mem_rdata_i;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            rd_pend    <= 1'b0;
            rd_kill    <= 1'b0;
            rd_tag     <= '0;
            starve_cnt <= '0;
        end else begin
            rd_pend <= ld_acc;
            rd_kill <= ld_acc & mispredict_i;
            if (ld_acc) begin
                rd_tag <= ld_tag_i;
            end
            if (st_acc) begin
                starve_cnt <= '0;
            end else if (ld_acc && st_v_i && starve_cnt != CNT_MAX) begin
                starve_cnt <= starve_cnt + 1'b1;
            end
        end
    end

    // The grant rule never accepts a load under mispredict, so a killed pending read is a bug.
    assert property (@(posedge clk_i) disable iff (reset_i) !(rd_pend && rd_kill));

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// tb/tb_dmem_port_arbiter.sv - randomized and directed self-checking bench for dmem_port_arbiter
module tb_dmem_port_arbiter;

    localparam int LIMIT = 4;

    logic        clk = 1'b0;
    logic        reset_i;
    logic        ld_v_i;
    logic [15:0] ld_addr_i;
    logic [2:0]  ld_tag_i;
    logic        ld_ready_o;
    logic        ld_resp_v_o;
    logic [2:0]  ld_resp_tag_o;
    logic [15:0] ld_resp_data_o;
    logic        st_v_i;
    logic [15:0] st_addr_i;
    logic [15:0] st_data_i;
    logic [1:0]  st_mask_i;
    logic        st_urgent_i;
    logic        st_ready_o;
    logic        mispredict_i;
    logic        mem_v_o;
    logic        mem_w_o;
    logic [15:0] mem_addr_o;
    logic [15:0] mem_wdata_o;
    logic [1:0]  mem_wmask_o;
    logic        mem_ready_i;
    logic [15:0] mem_rdata_i;

    int n_cmp = 0;
    int n_err = 0;

    int         m_cnt  = 0;
    bit         m_pend = 0;
    logic [2:0] m_tag  = '0;

    always #5 clk = ~clk;

    dmem_port_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
        .clk_i(clk), .reset_i(reset_i),
        .ld_v_i(ld_v_i), .ld_addr_i(ld_addr_i), .ld_tag_i(ld_tag_i), .ld_ready_o(ld_ready_o),
        .ld_resp_v_o(ld_resp_v_o), .ld_resp_tag_o(ld_resp_tag_o), .ld_resp_data_o(ld_resp_data_o),
        .st_v_i(st_v_i), .st_addr_i(st_addr_i), .st_data_i(st_data_i), .st_mask_i(st_mask_i),
        .st_urgent_i(st_urgent_i), .st_ready_o(st_ready_o), .mispredict_i(mispredict_i),
        .mem_v_o(mem_v_o), .mem_w_o(mem_w_o), .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
        .mem_wmask_o(mem_wmask_o), .mem_ready_i(mem_ready_i), .mem_rdata_i(mem_rdata_i)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic set_in(input bit ldv, input logic [15:0] la, input logic [2:0] lt,
                          input bit stv, input logic [15:0] sa, input logic [15:0] sd,
                          input logic [1:0] sm, input bit urg, input bit mis, input bit rdy);
        ld_v_i = ldv; ld_addr_i = la; ld_tag_i = lt;
        st_v_i = stv; st_addr_i = sa; st_data_i = sd; st_mask_i = sm;
        st_urgent_i = urg; mispredict_i = mis; mem_ready_i = rdy;
    endtask

    // Inputs are already applied in the low phase; compare against the model, then advance it.
    task automatic cycle();
        int  winner;
        bit  ld_live;
        bit  ld_done;
        bit  st_done;
        bit  resp_exp;
        #1;
        ld_live = ld_v_i && !mispredict_i;
        if (st_v_i && (st_urgent_i || m_cnt >= LIMIT || !ld_live)) winner = 2;
        else if (ld_live) winner = 1;
        else winner = 0;
        ld_done  = (winner == 1) && mem_ready_i;
        st_done  = (winner == 2) && mem_ready_i;
        resp_exp = m_pend && !mispredict_i;

        if (reset_i) begin
            check("rst_mem_v", mem_v_o, 0);
            check("rst_mem_w", mem_w_o, 0);
            check("rst_addr", mem_addr_o, 0);
            check("rst_wdata", mem_wdata_o, 0);
            check("rst_wmask", mem_wmask_o, 0);
            check("rst_ld_ready", ld_ready_o, 0);
            check("rst_st_ready", st_ready_o, 0);
            check("rst_resp_v", ld_resp_v_o, 0);
            m_cnt = 0; m_pend = 0; m_tag = '0;
        end else begin
            check("mem_v", mem_v_o, winner != 0);
            check("mem_w", mem_w_o, winner == 2);
            if (winner != 0) check("mem_addr", mem_addr_o, winner == 2 ? st_addr_i : ld_addr_i);
            check("mem_wdata", mem_wdata_o, winner == 2 ? st_data_i : 16'h0);
            check("mem_wmask", mem_wmask_o, winner == 2 ? st_mask_i : 2'b00);
            check("ld_ready", ld_ready_o, ld_done);
            check("st_ready", st_ready_o, st_done);
            check("resp_v", ld_resp_v_o, resp_exp);
            if (resp_exp) begin
                check("resp_tag", ld_resp_tag_o, m_tag);
                check("resp_data", ld_resp_data_o, mem_rdata_i);
            end
            m_pend = ld_done;
            if (ld_done) m_tag = ld_tag_i;
            if (st_done) m_cnt = 0;
            else if (ld_done && st_v_i && m_cnt < LIMIT) m_cnt++;
        end
    endtask

    initial begin
        logic [5:0] st_hist;

        reset_i = 1'b1;
        mem_rdata_i = '0;
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        repeat (2) begin @(negedge clk); cycle(); end

        // Load only
        @(negedge clk); reset_i = 1'b0;
        set_in(1, 16'h0040, 3'd3, 0, 0, 0, 0, 0, 0, 1);
        mem_rdata_i = 16'hBEEF;
        cycle();
        check("lo_mem_w", mem_w_o, 0);
        @(negedge clk); set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        cycle();
        check("lo_resp_v", ld_resp_v_o, 1);
        check("lo_resp_tag", ld_resp_tag_o, 3);
        check("lo_resp_data", ld_resp_data_o, 16'hBEEF);

        // Contention: store only gets through once the counter saturates
        st_hist = '0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            set_in(1, 16'h0100 + 16'(i), 3'(i), 1, 16'h0200, 16'hA5A5, 2'b11, 0, 0, 1);
            mem_rdata_i = 16'(i * 7 + 1);
            cycle();
            st_hist[i] = st_ready_o;
        end
        check("contend_order", st_hist, 6'b010000);

        // Urgent store beats a load
        @(negedge clk);
        set_in(1, 16'h0300, 3'd5, 1, 16'h0400, 16'h1234, 2'b01, 1, 0, 1);
        cycle();
        check("urg_mem_w", mem_w_o, 1);
        check("urg_wmask", mem_wmask_o, 2'b01);
        check("urg_st_ready", st_ready_o, 1);
        check("urg_ld_ready", ld_ready_o, 0);

        // Backpressure
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); set_in(1, 16'h0500, 3'd6, 0, 0, 0, 0, 0, 0, 0);
            cycle();
            check("bp_ld_ready", ld_ready_o, 0);
        end
        @(negedge clk); set_in(1, 16'h0500, 3'd6, 0, 0, 0, 0, 0, 0, 1);
        cycle();
        @(negedge clk); set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 1); mem_rdata_i = 16'h5A5A;
        cycle();
        check("bp_resp_v", ld_resp_v_o, 1);
        check("bp_resp_tag", ld_resp_tag_o, 6);

        // Mispredict in the response cycle, store still drains
        @(negedge clk); set_in(1, 16'h0600, 3'd2, 0, 0, 0, 0, 0, 0, 1);
        cycle();
        @(negedge clk); set_in(1, 16'h0610, 3'd1, 1, 16'h0700, 16'hCAFE, 2'b10, 0, 1, 1);
        cycle();
        check("mis_resp_v", ld_resp_v_o, 0);
        check("mis_st_ready", st_ready_o, 1);

        // Reset with a read pending
        @(negedge clk); set_in(1, 16'h0800, 3'd4, 0, 0, 0, 0, 0, 0, 1);
        cycle();
        @(negedge clk); reset_i = 1'b1;
        cycle();
        check("rp_resp_v", ld_resp_v_o, 0);
        @(negedge clk); reset_i = 1'b0; set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        cycle();
        check("rp_after_resp_v", ld_resp_v_o, 0);

        // Random traffic
        for (int i = 0; i < 500; i++) begin
            @(negedge clk);
            reset_i = ($urandom_range(99) < 3);
            set_in($urandom_range(99) < 60, 16'($urandom), 3'($urandom),
                   $urandom_range(99) < 50, 16'($urandom), 16'($urandom), 2'($urandom),
                   $urandom_range(99) < 15, $urandom_range(99) < 10, $urandom_range(99) < 80);
            mem_rdata_i = 16'($urandom);
            cycle();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
